// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared types and default constants for the spiking-neuron
//                slice: neuron state encoding, default neuron parameters and
//                the spike-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    typedef enum logic [0:0] {
        INTEGRATE = 1'b0,
        REFRAC    = 1'b1
    } lif_state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_THRESHOLD     = 200;
    localparam int DEF_LEAK_SHIFT    = 3;
    localparam int DEF_REFRAC_CYCLES = 4;
    localparam int SPIKE_CNT_W       = 16;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/refrac_timer.sv
`default_nettype none
// ============================================================================
//  Module      : refrac_timer
//  Description : 4-bit loadable down-counter that times the refractory
//                period. Loading takes priority over counting; the counter
//                stops at zero.
//  Ports       : clk, rst_n   - clock / synchronous active-low reset
//                i_load       - load i_load_val this edge
//                i_load_val   - value to load
//                o_active     - counter is non-zero
//                o_done       - counter is 1: the upcoming edge ends the period
//  Revision    : 1.0 - initial release
// ============================================================================
module refrac_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_active,
    output logic       o_done
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_active = (r_count != 4'd0);
    assign o_done   = (r_count == 4'd1);

endmodule : refrac_timer
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : Leaky integrate-and-fire neuron. Each cycle the membrane
//                leaks by membrane >> LEAK_SHIFT and, on a pre-synaptic spike,
//                integrates the synaptic weight (saturating, never wrapping).
//                Crossing THRESHOLD emits a one-cycle post spike, reloads the
//                membrane with V_RESET and enters a fixed refractory period.
//  Ports       : clk, rst_n      - clock / synchronous active-low reset
//                i_pre_spike     - pre-synaptic spike
//                i_weight        - unsigned synaptic weight
//                o_post_spike    - registered one-cycle fire pulse
//                o_membrane      - registered membrane potential
//                o_refractory    - neuron is in the refractory state
//                o_spike_count   - saturating count of fires since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron
    import snn_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int THRESHOLD     = DEF_THRESHOLD,
    parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
    parameter int REFRAC_CYCLES = DEF_REFRAC_CYCLES,
    parameter int V_RESET       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_pre_spike,
    input  logic [WIDTH-1:0]       i_weight,
    output logic                   o_post_spike,
    output logic [WIDTH-1:0]       o_membrane,
    output logic                   o_refractory,
    output logic [SPIKE_CNT_W-1:0] o_spike_count
);

    localparam logic [WIDTH:0]   c_V_MAX     = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] c_THRESHOLD = WIDTH'(THRESHOLD);
    localparam logic [WIDTH-1:0] c_V_RESET   = WIDTH'(V_RESET);
    localparam logic [3:0]       c_REFRAC    = 4'(REFRAC_CYCLES);

    lif_state_t             r_state;
    logic [WIDTH-1:0]       r_membrane;
    logic                   r_post_spike;
    logic [SPIKE_CNT_W-1:0] r_spike_count;

    lif_state_t             w_state_next;
    logic [WIDTH-1:0]       w_membrane_next;
    logic                   w_post_next;
    logic [SPIKE_CNT_W-1:0] w_count_next;
    logic                   w_timer_load;
    logic                   w_timer_active;
    logic                   w_timer_done;

    // Leak/integrate datapath, one bit wider than the membrane. The leak is
    // never larger than the membrane, so the subtraction cannot underflow;
    // only the weight addition can overflow, and that is clamped.
    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_v_next;

    assign w_leak   = r_membrane >> LEAK_SHIFT;
    assign w_sum    = {1'b0, r_membrane} - {1'b0, w_leak}
                    + (i_pre_spike ? {1'b0, i_weight} : {(WIDTH+1){1'b0}});
    assign w_v_next = (w_sum > c_V_MAX) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

    always_comb begin
        w_state_next    = r_state;
        w_membrane_next = r_membrane;
        w_post_next     = 1'b0;
        w_count_next    = r_spike_count;
        w_timer_load    = 1'b0;

        case (r_state)
            INTEGRATE: begin
                if (w_v_next >= c_THRESHOLD) begin
                    w_membrane_next = c_V_RESET;
                    w_post_next     = 1'b1;
                    if (r_spike_count != {SPIKE_CNT_W{1'b1}}) begin
                        w_count_next = r_spike_count + SPIKE_CNT_W'(1);
                    end
                    // A zero-length refractory period keeps the neuron
                    // integrating, allowing back-to-back fires.
                    if (c_REFRAC != 4'd0) begin
                        w_state_next = REFRAC;
                        w_timer_load = 1'b1;
                    end
                end else begin
                    w_membrane_next = w_v_next;
                end
            end
            REFRAC: begin
                w_membrane_next = c_V_RESET;
                // An idle timer here would mean a lost load; leave rather
                // than lock the neuron up.
                if (w_timer_done || !w_timer_active) begin
                    w_state_next = INTEGRATE;
                end
            end
            default: begin
                w_state_next = INTEGRATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= INTEGRATE;
            r_membrane    <= {WIDTH{1'b0}};
            r_post_spike  <= 1'b0;
            r_spike_count <= {SPIKE_CNT_W{1'b0}};
        end else begin
            r_state       <= w_state_next;
            r_membrane    <= w_membrane_next;
            r_post_spike  <= w_post_next;
            r_spike_count <= w_count_next;
        end
    end

    refrac_timer u_refrac_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (c_REFRAC),
        .o_active   (w_timer_active),
        .o_done     (w_timer_done)
    );

    assign o_post_spike  = r_post_spike;
    assign o_membrane    = r_membrane;
    assign o_refractory  = (r_state == REFRAC);
    assign o_spike_count = r_spike_count;

endmodule : lif_neuron
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron
//  Description : Self-checking bench for lif_neuron. Two instances share the
//                inputs: A with default parameters, B with THRESHOLD=255 and
//                no refractory period. Both are compared every cycle with an
//                arithmetic reference model; directed steps add fixed
//                expected values for the key traces.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pre = 1'b0;
    logic [7:0]  wt = 8'd0;

    logic        post_a, refr_a, post_b, refr_b;
    logic [7:0]  mem_a, mem_b;
    logic [15:0] cnt_a, cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lif_neuron u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pre_spike   (pre),
        .i_weight      (wt),
        .o_post_spike  (post_a),
        .o_membrane    (mem_a),
        .o_refractory  (refr_a),
        .o_spike_count (cnt_a)
    );

    lif_neuron #(.THRESHOLD(255), .REFRAC_CYCLES(0)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pre_spike   (pre),
        .i_weight      (wt),
        .o_post_spike  (post_b),
        .o_membrane    (mem_b),
        .o_refractory  (refr_b),
        .o_spike_count (cnt_b)
    );

    // Reference model: index 0 models A, index 1 models B.
    int th[2]     = '{200, 255};
    int rc[2]     = '{4, 0};
    int m_mem[2]  = '{0, 0};
    int m_left[2] = '{0, 0};
    int m_cnt[2]  = '{0, 0};
    int m_post[2] = '{0, 0};

    task automatic model_update(input logic r, input logic p, input int w);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_mem[k] = 0; m_left[k] = 0; m_cnt[k] = 0; m_post[k] = 0;
            end else if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
                m_mem[k]  = 0;
                m_post[k] = 0;
            end else begin
                int v;
                v = m_mem[k] - m_mem[k] / 8 + (p ? w : 0);
                if (v > 255) v = 255;
                if (v >= th[k]) begin
                    m_post[k] = 1;
                    m_mem[k]  = 0;
                    if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
                    m_left[k] = rc[k];
                end else begin
                    m_post[k] = 0;
                    m_mem[k]  = v;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("A.membrane",   {24'd0, mem_a},  m_mem[0]);
        check("A.post_spike", {31'd0, post_a}, m_post[0]);
        check("A.refractory", {31'd0, refr_a}, (m_left[0] > 0) ? 1 : 0);
        check("A.spike_count",{16'd0, cnt_a},  m_cnt[0]);
        check("B.membrane",   {24'd0, mem_b},  m_mem[1]);
        check("B.post_spike", {31'd0, post_b}, m_post[1]);
        check("B.refractory", {31'd0, refr_b}, (m_left[1] > 0) ? 1 : 0);
        check("B.spike_count",{16'd0, cnt_b},  m_cnt[1]);
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic r, input logic p, input logic [7:0] w);
        rst_n = r; pre = p; wt = w;
        @(posedge clk);
        #1;
        model_update(r, p, int'(w));
        check_model();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle.
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'd0);
            check("idle.membrane", {24'd0, mem_a}, 0);
            check("idle.count",    {16'd0, cnt_a}, 0);
        end

        // Integrate 64 four times: 64, 120, 169, fire.
        step(1'b1, 1'b1, 8'd64); check("int.mem1", {24'd0, mem_a}, 64);
        step(1'b1, 1'b1, 8'd64); check("int.mem2", {24'd0, mem_a}, 120);
        step(1'b1, 1'b1, 8'd64); check("int.mem3", {24'd0, mem_a}, 169);
        step(1'b1, 1'b1, 8'd64);
        check("int.fire",  {31'd0, post_a}, 1);
        check("int.reset", {24'd0, mem_a},  0);
        check("int.count", {16'd0, cnt_a},  1);
        for (int i = 0; i < 4; i++) begin
            check("int.refr", {31'd0, refr_a}, 1);
            step(1'b1, 1'b0, 8'd0);
            check("int.nopost", {31'd0, post_a}, 0);
        end
        check("int.refr_end", {31'd0, refr_a}, 0);

        // Leak trace from 120.
        step(1'b1, 1'b1, 8'd64);
        step(1'b1, 1'b1, 8'd64); check("leak.start", {24'd0, mem_a}, 120);
        step(1'b1, 1'b0, 8'd0);  check("leak.1", {24'd0, mem_a}, 105);
        step(1'b1, 1'b0, 8'd0);  check("leak.2", {24'd0, mem_a}, 92);
        step(1'b1, 1'b0, 8'd0);  check("leak.3", {24'd0, mem_a}, 81);
        step(1'b1, 1'b0, 8'd0);  check("leak.4", {24'd0, mem_a}, 71);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'd0);
        check("leak.floor", {24'd0, mem_a}, 7);

        // Refractory blocking: fire, then 255 during the whole period.
        step(1'b1, 1'b1, 8'd255);
        check("blk.fire", {31'd0, post_a}, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'd255);
            check("blk.mem",  {24'd0, mem_a},  0);
            check("blk.post", {31'd0, post_a}, 0);
        end
        step(1'b1, 1'b1, 8'd255);
        check("blk.refire", {31'd0, post_a}, 1);

        // Saturation on B: 200, then 375 clamped to 255 fires.
        step(1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd200); check("sat.mem", {24'd0, mem_b}, 200);
        step(1'b1, 1'b1, 8'd200); check("sat.fire", {31'd0, post_b}, 1);

        // Reset during the second refractory cycle, then replay 64 x4.
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd64);
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd255);
        check("rst.refr",  {31'd0, refr_a}, 0);
        check("rst.count", {16'd0, cnt_a},  0);
        step(1'b1, 1'b1, 8'd64); check("rst.mem1", {24'd0, mem_a}, 64);
        step(1'b1, 1'b1, 8'd64); check("rst.mem2", {24'd0, mem_a}, 120);
        step(1'b1, 1'b1, 8'd64); check("rst.mem3", {24'd0, mem_a}, 169);
        step(1'b1, 1'b1, 8'd64); check("rst.fire", {31'd0, post_a}, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)));
        end

        // Back-to-back fires on B until the spike counter saturates.
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 65540; i++) begin
            rst_n = 1'b1; pre = 1'b1; wt = 8'd255;
            @(posedge clk);
            #1;
            model_update(1'b1, 1'b1, 255);
        end
        check_model();
        check("sat.count", {16'd0, cnt_b}, 32'h0000_FFFF);
        step(1'b1, 1'b1, 8'd255);
        check("sat.hold", {16'd0, cnt_b}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_lif_neuron
`default_nettype wire

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron that produces the `post_spike` consumed by the STDP stage.
- Integrates the STDP-produced synaptic `weight` on each `pre_spike`, applies a shift-based leak every cycle, and fires when the membrane crosses threshold.
- After firing, the neuron is held in a fixed refractory period.
- Sits directly downstream of the weight-update stage; its `post_spike` closes the learning loop back into that stage.

Parameters:
- WIDTH, 8: membrane and weight width in bits.
- THRESHOLD, 200: firing threshold; the neuron fires when the membrane is >= THRESHOLD. Legal range 1..2^WIDTH-1.
- LEAK_SHIFT, 3: leak per cycle is membrane >> LEAK_SHIFT. Legal range 1..WIDTH-1.
- REFRAC_CYCLES, 4: number of cycles held in refractory after a spike. Legal range 0..15.
- V_RESET, 0: membrane value loaded on fire and on reset exit.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- pre_spike, input, 1: pre-synaptic spike; sampled every rising edge.
- weight, input, WIDTH: synaptic weight, unsigned; added on `pre_spike`.
- post_spike, output, 1: registered one-cycle fire pulse.
- membrane, output, WIDTH: current membrane potential, registered.
- refractory, output, 1: high while in the REFRAC state.
- spike_count, output, 16: total fires since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low at a rising edge) sets:
  - state = INTEGRATE
  - membrane = 0
  - post_spike = 0
  - refractory = 0
  - spike_count = 0
  - refractory timer = 0
- Reset overrides everything, including mid-refractory and a same-cycle fire.
- States: INTEGRATE, REFRAC. `refractory` = (state == REFRAC).
- INTEGRATE datapath, computed at WIDTH+1 bits:
  - v_next = membrane - (membrane >> LEAK_SHIFT) + (pre_spike ? weight : 0)
  - If v_next > 2^WIDTH-1, clamp to 2^WIDTH-1. No wrap-around, ever.
  - Leak truncates, so a membrane below 2^LEAK_SHIFT does not decay. This is intended.
- INTEGRATE, v_next >= THRESHOLD, at that edge:
  - post_spike <= 1, membrane <= V_RESET, spike_count increments (saturating).
  - If REFRAC_CYCLES == 0: state stays INTEGRATE.
  - Otherwise: state <= REFRAC and timer <= REFRAC_CYCLES.
  - Latency: `post_spike` is high in the cycle immediately after the edge that sampled the crossing input.
- INTEGRATE, v_next < THRESHOLD: membrane <= v_next, post_spike <= 0.
- REFRAC state:
  - pre_spike and weight are ignored; membrane is held at V_RESET; post_spike <= 0.
  - timer decrements each edge; when timer == 1 at an edge, state <= INTEGRATE.
  - The neuron therefore spends exactly REFRAC_CYCLES cycles in REFRAC.
  - A `pre_spike` on the first INTEGRATE cycle after REFRAC is integrated normally.
- `post_spike` is never high two consecutive cycles when REFRAC_CYCLES >= 1.
- When REFRAC_CYCLES == 0, back-to-back fires are legal if the input sustains them.
- `weight` is used only in the cycle `pre_spike` is high; there is no registering or hold requirement on it.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `snn_pkg`:
  - state enum (INTEGRATE, REFRAC)
  - default constants: WIDTH=8, THRESHOLD=200, LEAK_SHIFT=3, REFRAC_CYCLES=4
  - spike_count width (16)
- One sub-module, `refrac_timer`:
  - 4-bit loadable down-counter with ports load, load_val, active, done.
  - Instantiated once; `done` drives the REFRAC->INTEGRATE transition.
- Leak/integrate/saturate datapath stays inline.

Test Plan (defaults unless stated):
- Reset then idle 10 cycles -> membrane=0, post_spike=0, refractory=0, spike_count=0 throughout.
- weight=64, pre_spike high 4 consecutive cycles:
  - membrane goes 64, 120, 169, then fires on the 4th edge.
  - post_spike=1 for exactly 1 cycle; membrane=0; refractory=1 for 4 cycles; spike_count=1.
- Leak: weight=64, pre_spike 2 cycles (membrane=120), then pre_spike low:
  - membrane goes 105, 92, 81, 71, ...
  - Membrane stays at 7 once it reaches 7.
- Refractory blocking: fire, then pre_spike=1 with weight=255 during all 4 REFRAC cycles:
  - membrane stays 0 and no post_spike.
  - On the first INTEGRATE cycle, 255 is integrated and the neuron fires again (255 >= 200).
- Saturation, THRESHOLD=255, weight=200: two pre_spikes -> 200, then 375 clamped to 255 -> fire, post_spike=1.
- Reset mid-operation:
  - rst_n low during the 2nd REFRAC cycle -> all outputs 0, state INTEGRATE.
  - After rst_n high, weight=64 ×4 reproduces the scenario-2 trace.
